// File: rtl/heavy_part_table_reader_pkg.sv
// Shared widths and field helpers for the heavy-part table read-issue stage.
package heavy_part_table_reader_pkg;

  localparam int TS_W = 64;

  function automatic int rec_width(input int key_w, input int val_w, input int cnt_w);
    return key_w + val_w + cnt_w;
  endfunction

  function automatic int out_width(input int time_w, input int key_w, input int val_w);
    return time_w + key_w + val_w;
  endfunction

  // Input record is {key, value, counter}, key in the MSBs.
  function automatic int key_lsb(input int val_w, input int cnt_w);
    return val_w + cnt_w;
  endfunction

  function automatic int val_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int idx_msb(input int hash_lsb, input int addr_w);
    return hash_lsb + addr_w - 1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/heavy_part_table_reader_fifo.sv
// First-word-fall-through FIFO: storage array plus a one-entry output stage.
// usedw counts every entry held, including the one presented on dout.
module hp_fwft_fifo
  import heavy_part_table_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int UW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [UW-1:0]    usedw
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [UW-1:0]    mem_cnt;
  logic             out_valid;
  logic             pop;
  logic             wr_acc;
  logic             load;

  assign pop    = rd && out_valid;
  // A pop in the same cycle frees a slot, so a write while full is still taken.
  assign wr_acc = wr && (!full || pop);
  assign load   = (mem_cnt != '0) && (!out_valid || pop);
  assign empty  = !out_valid;
  assign full   = (usedw == UW'(DEPTH));

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the output stage refill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      usedw     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (load)     out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
      mem_cnt <= mem_cnt + UW'(wr_acc) - UW'(load);
      usedw   <= usedw + UW'(wr_acc) - UW'(pop);
    end
  end

endmodule

// File: rtl/heavy_part_table_reader.sv
// Read-issue stage: queues flow records, issues one bucket read per cycle,
// and holds back a record whose bucket was read within the last INFLIGHT cycles.
module heavy_part_table_reader
  import heavy_part_table_reader_pkg::*;
#(
  parameter int KEY_W      = 32,
  parameter int VAL_W      = 32,
  parameter int CNT_W      = 32,
  parameter int TIME_W     = TS_W,
  parameter int ADDR_W     = 12,
  parameter int HASH_LSB   = 68,
  parameter int FIFO_DEPTH = 512,
  parameter int AF_LEVEL   = 256,
  parameter int INFLIGHT   = 4,
  localparam int REC_W = rec_width(KEY_W, VAL_W, CNT_W),
  localparam int OUT_W = out_width(TIME_W, KEY_W, VAL_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_in_wr,
  input  logic [REC_W-1:0]  rec_in,
  output logic              rec_in_alf,
  input  logic              hazard_en,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_rdaddr,
  output logic              rec_out_wr,
  output logic [OUT_W-1:0]  rec_out,
  input  logic              rec_out_alf,
  output logic [31:0]       drop_cnt,
  output logic [31:0]       stall_cnt
);

  localparam int KEY_LSB = key_lsb(VAL_W, CNT_W);
  localparam int VAL_LSB = val_lsb(CNT_W);
  localparam int IDX_MSB = idx_msb(HASH_LSB, ADDR_W);
  localparam int FW      = KEY_W + VAL_W + ADDR_W;
  localparam int UW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [UW-1:0] AF_LVL = UW'(AF_LEVEL);

  // Only key, value and bucket index travel through the FIFO; the counter
  // field is not forwarded, so its bits are deliberately left unconsumed.
  logic              unused_rec_bits;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [UW-1:0]     fifo_usedw;
  logic [KEY_W-1:0]  head_key;
  logic [VAL_W-1:0]  head_val;
  logic [ADDR_W-1:0] head_addr;
  logic [TIME_W-1:0] ts;
  logic [INFLIGHT-1:0] win_valid;
  logic [ADDR_W-1:0] win_addr [INFLIGHT];
  logic              win_hit;
  logic              hazard;
  logic              ready;
  logic              issue;
  logic              stall;
  logic              drop;

  assign unused_rec_bits = ^rec_in;
  assign fifo_din = {rec_in[KEY_LSB +: KEY_W], rec_in[VAL_LSB +: VAL_W],
                     rec_in[IDX_MSB:HASH_LSB]};

  hp_fwft_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rec_in_wr),
    .din   (fifo_din),
    .rd    (issue),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .usedw (fifo_usedw)
  );

  assign head_key  = head[ADDR_W + VAL_W +: KEY_W];
  assign head_val  = head[ADDR_W +: VAL_W];
  assign head_addr = head[ADDR_W-1:0];

  // Look for the head bucket anywhere in the in-flight window.
  always_comb begin
    win_hit = 1'b0;
    for (int i = 0; i < INFLIGHT; i++) begin
      if (win_valid[i] && (win_addr[i] == head_addr)) win_hit = 1'b1;
    end
  end

  assign hazard = hazard_en && win_hit;
  assign ready  = !fifo_empty && !rec_out_alf;
  assign issue  = ready && !hazard;
  assign stall  = ready && hazard;
  assign drop   = rec_in_wr && fifo_full && !issue;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // In-flight window shifts every cycle; bubbles enter as invalid entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid <= '0;
      for (int i = 0; i < INFLIGHT; i++) win_addr[i] <= '0;
    end else begin
      for (int i = INFLIGHT - 1; i > 0; i--) begin
        win_valid[i] <= win_valid[i-1];
        win_addr[i]  <= win_addr[i-1];
      end
      win_valid[0] <= issue;
      win_addr[0]  <= head_addr;
    end
  end

  // Registered issue outputs; address and record hold between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_rden   <= 1'b0;
      ram_rdaddr <= '0;
      rec_out_wr <= 1'b0;
      rec_out    <= '0;
    end else begin
      ram_rden   <= issue;
      rec_out_wr <= issue;
      if (issue) begin
        ram_rdaddr <= head_addr;
        rec_out    <= {ts, head_key, head_val};
      end
    end
  end

  // Occupancy flag and saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_in_alf <= 1'b0;
      drop_cnt   <= '0;
      stall_cnt  <= '0;
    end else begin
      rec_in_alf <= (fifo_usedw >= AF_LVL);
      if (drop)  drop_cnt  <= sat_inc32(drop_cnt);
      if (stall) stall_cnt <= sat_inc32(stall_cnt);
    end
  end

endmodule

// File: tb/tb_heavy_part_table_reader.sv
// Directed bench for heavy_part_table_reader. The bucket index is taken from
// the counter field (HASH_LSB = 0) so key, value and index are independent.
module tb_heavy_part_table_reader;

  logic          clk = 1'b0;
  logic          reset;
  logic          rec_in_wr;
  logic [95:0]   rec_in;
  logic          rec_in_alf;
  logic          hazard_en;
  logic          ram_rden;
  logic [11:0]   ram_rdaddr;
  logic          rec_out_wr;
  logic [127:0]  rec_out;
  logic          rec_out_alf;
  logic [31:0]   drop_cnt;
  logic [31:0]   stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c0;
  int c1;

  typedef struct {
    int           cyc;
    logic [127:0] data;
    logic [11:0]  addr;
  } obs_t;
  obs_t obs_q[$];

  always #5 clk = ~clk;

  heavy_part_table_reader #(.HASH_LSB(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .rec_in_wr   (rec_in_wr),
    .rec_in      (rec_in),
    .rec_in_alf  (rec_in_alf),
    .hazard_en   (hazard_en),
    .ram_rden    (ram_rden),
    .ram_rdaddr  (ram_rdaddr),
    .rec_out_wr  (rec_out_wr),
    .rec_out     (rec_out),
    .rec_out_alf (rec_out_alf),
    .drop_cnt    (drop_cnt),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; samples 1 ns after the edge and logs any issued record.
  task automatic tick();
    obs_t o;
    @(posedge clk);
    #1;
    cyc++;
    if (rec_out_wr === 1'b1) begin
      o.cyc  = cyc;
      o.data = rec_out;
      o.addr = ram_rdaddr;
      obs_q.push_back(o);
    end
  endtask

  task automatic put(input logic [31:0] k, input logic [31:0] v, input logic [11:0] idx);
    rec_in_wr = 1'b1;
    rec_in    = {k, v, 20'h0, idx};
    tick();
    rec_in_wr = 1'b0;
  endtask

  function automatic logic [127:0] exp_out(input int ts, input logic [31:0] k, input logic [31:0] v);
    logic [63:0] t;
    t = 64'(unsigned'(ts));
    return {t, k, v};
  endfunction

  initial begin
    reset       = 1'b1;
    rec_in_wr   = 1'b0;
    rec_in      = '0;
    hazard_en   = 1'b1;
    rec_out_alf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden",   ram_rden,   0);
    chk("rst_outwr",  rec_out_wr, 0);
    chk("rst_recout", rec_out,    0);
    chk("rst_addr",   ram_rdaddr, 0);
    chk("rst_alf",    rec_in_alf, 0);
    chk("rst_drop",   drop_cnt,   0);
    chk("rst_stall",  stall_cnt,  0);
    reset = 1'b0;
    cyc = 0;
    obs_q.delete();
    repeat (2) tick();

    // Single record latency and contents.
    c0 = cyc;
    put(32'h0A00_0001, 32'd5, 12'h123);
    tick();
    chk("t1_rden_early", ram_rden, 0);
    tick();
    chk("t1_rden",   ram_rden,   1);
    chk("t1_outwr",  rec_out_wr, 1);
    chk("t1_addr",   ram_rdaddr, 12'h123);
    chk("t1_recout", rec_out, exp_out(c0 + 2, 32'h0A00_0001, 32'd5));
    tick();
    chk("t1_rden_pulse", ram_rden, 0);
    chk("t1_addr_hold",  ram_rdaddr, 12'h123);

    // Eight distinct buckets back to back.
    repeat (6) tick();
    obs_q.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) put(32'hB000_0000 + 32'(i), 32'h100 + 32'(i), 12'(12'h200 + i * 5));
    repeat (8) tick();
    chk("t2_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      chk("t2_cyc",  obs_q[i].cyc, c0 + 3 + i);
      chk("t2_data", obs_q[i].data, exp_out(c0 + 2 + i, 32'hB000_0000 + 32'(i), 32'h100 + 32'(i)));
      chk("t2_addr", obs_q[i].addr, 12'(12'h200 + i * 5));
    end

    // Same bucket three times, window ignored.
    hazard_en = 1'b0;
    repeat (6) tick();
    obs_q.delete();
    c0 = cyc;
    for (int i = 0; i < 3; i++) put(32'hC000_0000 + 32'(i), 32'(i), 12'h3A5);
    repeat (10) tick();
    chk("t3a_count", obs_q.size(), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      chk("t3a_cyc",  obs_q[i].cyc, c0 + 3 + i);
      chk("t3a_data", obs_q[i].data, exp_out(c0 + 2 + i, 32'hC000_0000 + 32'(i), 32'(i)));
    end
    chk("t3a_stall", stall_cnt, 0);

    // Same bucket three times, window enforced: spacing INFLIGHT+1.
    hazard_en = 1'b1;
    repeat (6) tick();
    obs_q.delete();
    c0 = cyc;
    for (int i = 0; i < 3; i++) put(32'hC100_0000 + 32'(i), 32'h10 + 32'(i), 12'h3A5);
    repeat (16) tick();
    chk("t3b_count", obs_q.size(), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      chk("t3b_cyc",  obs_q[i].cyc, c0 + 3 + 5 * i);
      chk("t3b_data", obs_q[i].data, exp_out(c0 + 2 + 5 * i, 32'hC100_0000 + 32'(i), 32'h10 + 32'(i)));
    end
    chk("t3b_stall", stall_cnt, 8);

    // Downstream backpressure for 10 cycles with 4 records queued.
    repeat (6) tick();
    obs_q.delete();
    rec_out_alf = 1'b1;
    for (int i = 0; i < 4; i++) put(32'hA400_0000 + 32'(i), 32'h40 + 32'(i), 12'(12'h700 + i));
    repeat (6) tick();
    chk("t4_blocked_count", obs_q.size(), 0);
    chk("t4_blocked_rden",  ram_rden, 0);
    c1 = cyc;
    rec_out_alf = 1'b0;
    repeat (8) tick();
    chk("t4_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk("t4_cyc",  obs_q[i].cyc, c1 + 1 + i);
      chk("t4_data", obs_q[i].data, exp_out(c1 + i, 32'hA400_0000 + 32'(i), 32'h40 + 32'(i)));
    end

    // Overflow: FIFO_DEPTH+3 writes with output blocked.
    repeat (6) tick();
    obs_q.delete();
    rec_out_alf = 1'b1;
    for (int j = 0; j < 515; j++) begin
      put(32'hD000_0000 + 32'(j), 32'h5A5A_0000 ^ 32'(j), 12'(j));
      if (j == 255) chk("t5_alf_below", rec_in_alf, 0);
      if (j == 256) chk("t5_alf_at",    rec_in_alf, 1);
    end
    tick();
    chk("t5_drop", drop_cnt, 3);
    chk("t5_alf_full", rec_in_alf, 1);
    chk("t5_none_out", obs_q.size(), 0);
    c1 = cyc;
    rec_out_alf = 1'b0;
    repeat (520) tick();
    chk("t5_count", obs_q.size(), 512);
    for (int j = 0; j < 512 && j < obs_q.size(); j++) begin
      chk("t5_data", obs_q[j].data, exp_out(c1 + j, 32'hD000_0000 + 32'(j), 32'h5A5A_0000 ^ 32'(j)));
      chk("t5_addr", obs_q[j].addr, 12'(j));
    end
    chk("t5_alf_drained", rec_in_alf, 0);

    // Reset in the middle of a burst.
    repeat (6) tick();
    obs_q.delete();
    for (int i = 0; i < 6; i++) put(32'hE000_0000 + 32'(i), 32'(i), 12'(12'h900 + i));
    chk("t6_inflight", rec_out_wr, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_rden",   ram_rden,   0);
    chk("t6_rst_outwr",  rec_out_wr, 0);
    chk("t6_rst_recout", rec_out,    0);
    chk("t6_rst_addr",   ram_rdaddr, 0);
    chk("t6_rst_drop",   drop_cnt,   0);
    chk("t6_rst_stall",  stall_cnt,  0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    obs_q.delete();
    repeat (5) tick();
    chk("t6_fifo_empty", obs_q.size(), 0);
    c0 = cyc;
    put(32'h0F0F_0F0F, 32'd7, 12'h0AB);
    repeat (2) tick();
    chk("t6_outwr",  rec_out_wr, 1);
    chk("t6_ts_restart", rec_out, exp_out(c0 + 2, 32'h0F0F_0F0F, 32'd7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/heavy_part_table_reader.md
# heavy_part_table_reader

Parametrised read-issue stage for the heavy-part bucket table. It buffers incoming flow records (key, value, counter) in an internal first-word-fall-through FIFO and extracts the bucket index from a configurable hash slice. It issues one RAM read per cycle, tags each record with a free-running timestamp and forwards it to the compare stage. Unlike the previous generation, it can issue back-to-back and stalls on bucket read-after-read hazards inside a configurable in-flight window, so the downstream read-modify-write never sees a stale bucket.

## Interface
- KEY_W, 32, key field width
- VAL_W, 32, value field width
- CNT_W, 32, counter field width (carried in, not forwarded)
- TIME_W, 64, timestamp width
- ADDR_W, 12, bucket address width (table depth 2^ADDR_W)
- HASH_LSB, 68, LSB of bucket index inside the input record; index = rec_in[HASH_LSB+ADDR_W-1:HASH_LSB]; HASH_LSB+ADDR_W <= REC_W
- FIFO_DEPTH, 512, input FIFO entries (power of two)
- AF_LEVEL, 256, almost-full threshold in entries
- INFLIGHT, 4, hazard window length in cycles (>= 1)
- Derived: REC_W = KEY_W+VAL_W+CNT_W; OUT_W = TIME_W+KEY_W+VAL_W
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rec_in_wr  in  1  write strobe for rec_in
- rec_in  in  REC_W  {key, value, counter}, key in MSBs
- rec_in_alf  out  1  FIFO occupancy >= AF_LEVEL
- hazard_en  in  1  1 = hazard stall active; 0 = window ignored
- ram_rden  out  1  bucket RAM read enable
- ram_rdaddr  out  ADDR_W  bucket RAM read address
- rec_out_wr  out  1  output record valid
- rec_out  out  OUT_W  {timestamp, key, value}
- rec_out_alf  in  1  downstream almost-full; blocks issue
- drop_cnt  out  32  records lost to FIFO overflow, saturating
- stall_cnt  out  32  cycles stalled by hazard, saturating

## Operation
- Timestamp: TIME_W counter, +1 every cycle, wraps to 0 after all-ones.
- head_addr = bucket index of FIFO head (combinational, FWFT).
- hazard = hazard_en && any window entry valid with addr == head_addr.
- issue = !empty && !rec_out_alf && !hazard; issue pops the FIFO the same cycle.
- On issue, registered: ram_rden=1, ram_rdaddr=head_addr, rec_out_wr=1, rec_out={timestamp, head key, head value}. With no issue: ram_rden=0, rec_out_wr=0, ram_rdaddr and rec_out hold their last values.
- Window: INFLIGHT-deep shift register of {valid, addr}; shifts every cycle; entry 0 loads {issue, head_addr}. Each bubble shifts in valid=0.
- Same bucket consecutively: second issue at earliest INFLIGHT+1 cycles after the first. Different buckets: one issue per cycle.
- Overflow: rec_in_wr while full drops the record, FIFO is unchanged, drop_cnt +1.
- Write and pop in the same cycle while full: pop frees the slot and the write is accepted.
- stall_cnt +1 in every cycle where !empty && !rec_out_alf && hazard.
- Both counters saturate at 2^32-1.
- hazard_en change takes effect the same cycle; window contents keep shifting regardless.
- No explicit FSM: the issue/idle decision is re-evaluated every cycle.

## Timing
- Reset (async assert, sync release): all outputs 0, timestamp 0, FIFO empty, window all invalid, counters 0.
- Latency: rec_in_wr at edge t into an empty FIFO gives the head visible after edge t+1; ram_rden/rec_out_wr are high after edge t+2.
- The timestamp in rec_out is the counter value in the issue cycle.
- rec_out_alf sampled combinationally; one in-flight output may follow its assertion, and downstream reserves >= 1 slot of margin.
- rec_in_alf registered from occupancy, updated one cycle after the change.
- Reset mid-stream: in-flight outputs drop to 0 immediately and FIFO contents are discarded.

## Structure
- Shared package: REC_W/OUT_W derivation functions, field-slice helpers (key/value/index extract), timestamp width constant.
- One sub-module: hp_fwft_fifo (parametrised width/depth, FWFT output, usedw, full/empty, active-high async reset).
- Hazard window and issue logic stay in the top module.

## Test plan
- Single record key=0x0A000001, val=5, index=0x123 into an empty block -> ram_rdaddr=0x123 and rec_out_wr after 2 cycles, rec_out={ts, 0x0A000001, 5}.
- 8 records with distinct indices, back-to-back -> 8 consecutive issue cycles, order preserved, timestamps incrementing by 1.
- 3 records with the same index, INFLIGHT=4, hazard_en=1 -> issues spaced 5 cycles apart, stall_cnt=8; same stimulus with hazard_en=0 -> 3 consecutive issues, stall_cnt=0.
- rec_out_alf held high for 10 cycles with 4 records queued -> no ram_rden during the hold, all 4 issue after release, none lost.
- Write FIFO_DEPTH+3 records with output blocked -> rec_in_alf high at 256, drop_cnt=3, first 512 records emerge intact.
- Assert reset mid-burst -> all outputs 0 asynchronously; after release the FIFO is empty and the timestamp restarts at 0.
